// File: rtl/mm_tile_scheduler.sv
// mm_tile_scheduler
//   Sequences a tiled matrix multiply C = A[rows x K] * B[K x cols] over one
//   A-side and one B-side memory buffer. One job descriptor is accepted in
//   IDLE. Each A row-tile is issued once with repeats = col_tiles. All B
//   col-tiles are then issued once each, with repeats = 1, before the next
//   A tile is issued. job_done pulses once both buffers are ready again
//   after the last instruction.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   job_valid / job_ready         job descriptor handshake (ready only in IDLE)
//   a_base_address, b_base_address tile-major bases, stride K*N
//   k_length, row_tiles, col_tiles job shape
//   a_instruction_* / b_instruction_* instruction handshakes + registered payloads
//   busy                          scheduler not idle
//   job_done                      one-cycle completion pulse
//   row_tile_index, col_tile_index current A / B tile
module mm_tile_scheduler #(
    parameter int N                    = 4,
    parameter int MEMORY_ADDRESS_BITS  = 64,
    parameter int MAX_MATRIX_LENGTH    = 4096,
    parameter int COUNTER_BITS         = $clog2(MAX_MATRIX_LENGTH + 1),
    parameter int REPEATS_COUNTER_BITS = $clog2((MAX_MATRIX_LENGTH / N) + 1)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            job_valid,
    output logic                            job_ready,
    input  logic [MEMORY_ADDRESS_BITS-1:0]  a_base_address,
    input  logic [MEMORY_ADDRESS_BITS-1:0]  b_base_address,
    input  logic [COUNTER_BITS-1:0]         k_length,
    input  logic [REPEATS_COUNTER_BITS-1:0] row_tiles,
    input  logic [REPEATS_COUNTER_BITS-1:0] col_tiles,
    output logic                            a_instruction_valid,
    input  logic                            a_instruction_ready,
    output logic [MEMORY_ADDRESS_BITS-1:0]  a_address,
    output logic [COUNTER_BITS-1:0]         a_length,
    output logic [REPEATS_COUNTER_BITS-1:0] a_repeats,
    output logic                            b_instruction_valid,
    input  logic                            b_instruction_ready,
    output logic [MEMORY_ADDRESS_BITS-1:0]  b_address,
    output logic [COUNTER_BITS-1:0]         b_length,
    output logic [REPEATS_COUNTER_BITS-1:0] b_repeats,
    output logic                            busy,
    output logic                            job_done,
    output logic [REPEATS_COUNTER_BITS-1:0] row_tile_index,
    output logic [REPEATS_COUNTER_BITS-1:0] col_tile_index
);

    localparam int MAB = MEMORY_ADDRESS_BITS;
    localparam int CB  = COUNTER_BITS;
    localparam int RCB = REPEATS_COUNTER_BITS;
    localparam logic [MAB-1:0] N_ADDR = MAB'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_A,
        S_ISSUE_B,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [MAB-1:0]   stride_q;
    logic [MAB-1:0]   b_base_q;
    logic [RCB-1:0]   rows_q;
    logic [RCB-1:0]   cols_q;

    logic [MAB-1:0]   k_ext;
    logic             accept;
    logic             empty_job;
    logic             last_col;
    logic             last_row;

    assign k_ext     = MAB'(k_length);
    assign accept    = job_ready && job_valid;
    assign empty_job = (k_length == '0) || (row_tiles == '0) || (col_tiles == '0);
    assign last_col  = (col_tile_index == cols_q - RCB'(1));
    assign last_row  = (row_tile_index == rows_q - RCB'(1));

    // The payload registers a_address/b_address double as the running tile
    // pointers, so they are only advanced at a transfer and remain stable
    // while the buffers apply backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= S_IDLE;
            job_ready           <= 1'b0;
            busy                <= 1'b0;
            job_done            <= 1'b0;
            a_instruction_valid <= 1'b0;
            b_instruction_valid <= 1'b0;
            a_address           <= '0;
            a_length            <= '0;
            a_repeats           <= '0;
            b_address           <= '0;
            b_length            <= '0;
            b_repeats           <= '0;
            row_tile_index      <= '0;
            col_tile_index      <= '0;
            stride_q            <= '0;
            b_base_q            <= '0;
            rows_q              <= '0;
            cols_q              <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        job_ready      <= 1'b0;
                        busy           <= 1'b1;
                        stride_q       <= k_ext * N_ADDR;
                        b_base_q       <= b_base_address;
                        rows_q         <= row_tiles;
                        cols_q         <= col_tiles;
                        row_tile_index <= '0;
                        col_tile_index <= '0;
                        a_address      <= a_base_address;
                        a_length       <= k_length;
                        a_repeats      <= col_tiles;
                        b_address      <= b_base_address;
                        b_length       <= k_length;
                        b_repeats      <= RCB'(1);
                        if (empty_job) begin
                            job_done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            a_instruction_valid <= 1'b1;
                            state               <= S_ISSUE_A;
                        end
                    end else begin
                        job_ready <= 1'b1;
                    end
                end

                S_ISSUE_A: begin
                    if (a_instruction_ready) begin
                        a_instruction_valid <= 1'b0;
                        b_instruction_valid <= 1'b1;
                        state               <= S_ISSUE_B;
                    end
                end

                S_ISSUE_B: begin
                    if (b_instruction_ready) begin
                        if (!last_col) begin
                            col_tile_index <= col_tile_index + RCB'(1);
                            b_address      <= b_address + stride_q;
                        end else if (!last_row) begin
                            col_tile_index      <= '0;
                            b_address           <= b_base_q;
                            row_tile_index      <= row_tile_index + RCB'(1);
                            a_address           <= a_address + stride_q;
                            b_instruction_valid <= 1'b0;
                            a_instruction_valid <= 1'b1;
                            state               <= S_ISSUE_A;
                        end else begin
                            b_instruction_valid <= 1'b0;
                            state               <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (a_instruction_ready && b_instruction_ready) begin
                        job_done <= 1'b1;
                        state    <= S_DONE;
                    end
                end

                S_DONE: begin
                    job_done  <= 1'b0;
                    busy      <= 1'b0;
                    job_ready <= 1'b1;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_tile_scheduler.sv
// tb_mm_tile_scheduler
//   Directed bench for mm_tile_scheduler with N=4, 64-bit addresses. Covers
//   reset state, a 2x3 job with full throughput, A-side backpressure, an
//   empty job, address wrap, job_valid held during a busy job, and reset
//   applied in the middle of a job.
module tb_mm_tile_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        job_valid;
    logic        job_ready;
    logic [63:0] a_base_address;
    logic [63:0] b_base_address;
    logic [12:0] k_length;
    logic [10:0] row_tiles;
    logic [10:0] col_tiles;
    logic        a_instruction_valid;
    logic        a_instruction_ready;
    logic [63:0] a_address;
    logic [12:0] a_length;
    logic [10:0] a_repeats;
    logic        b_instruction_valid;
    logic        b_instruction_ready;
    logic [63:0] b_address;
    logic [12:0] b_length;
    logic [10:0] b_repeats;
    logic        busy;
    logic        job_done;
    logic [10:0] row_tile_index;
    logic [10:0] col_tile_index;

    int unsigned errors = 0;
    int unsigned checks = 0;

    mm_tile_scheduler #(
        .N                   (4),
        .MEMORY_ADDRESS_BITS (64),
        .MAX_MATRIX_LENGTH   (4096)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .job_valid           (job_valid),
        .job_ready           (job_ready),
        .a_base_address      (a_base_address),
        .b_base_address      (b_base_address),
        .k_length            (k_length),
        .row_tiles           (row_tiles),
        .col_tiles           (col_tiles),
        .a_instruction_valid (a_instruction_valid),
        .a_instruction_ready (a_instruction_ready),
        .a_address           (a_address),
        .a_length            (a_length),
        .a_repeats           (a_repeats),
        .b_instruction_valid (b_instruction_valid),
        .b_instruction_ready (b_instruction_ready),
        .b_address           (b_address),
        .b_length            (b_length),
        .b_repeats           (b_repeats),
        .busy                (busy),
        .job_done            (job_done),
        .row_tile_index      (row_tile_index),
        .col_tile_index      (col_tile_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input logic [63:0] a, input logic [63:0] b,
                           input logic [12:0] k, input logic [10:0] r, input logic [10:0] c);
        a_base_address = a;
        b_base_address = b;
        k_length       = k;
        row_tiles      = r;
        col_tiles      = c;
    endtask

    task automatic accept_job();
        job_valid = 1'b1;
        step();
        job_valid = 1'b0;
    endtask

    // Waits (bounded) for an A instruction, checks it, then lets it transfer.
    task automatic wait_a(input string tag, input logic [63:0] addr, input logic [12:0] len,
                          input logic [10:0] rep, input logic [10:0] ri);
        int unsigned n = 0;
        while (!a_instruction_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_a_valid"}, 64'(a_instruction_valid), 64'd1);
        chk({tag, "_excl"}, 64'(b_instruction_valid), 64'd0);
        chk({tag, "_a_addr"}, a_address, addr);
        chk({tag, "_a_len"}, 64'(a_length), 64'(len));
        chk({tag, "_a_rep"}, 64'(a_repeats), 64'(rep));
        chk({tag, "_row_idx"}, 64'(row_tile_index), 64'(ri));
        step();
    endtask

    task automatic wait_b(input string tag, input logic [63:0] addr, input logic [12:0] len,
                          input logic [10:0] ci);
        int unsigned n = 0;
        while (!b_instruction_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_b_valid"}, 64'(b_instruction_valid), 64'd1);
        chk({tag, "_excl"}, 64'(a_instruction_valid), 64'd0);
        chk({tag, "_b_addr"}, b_address, addr);
        chk({tag, "_b_len"}, 64'(b_length), 64'(len));
        chk({tag, "_b_rep"}, 64'(b_repeats), 64'd1);
        chk({tag, "_col_idx"}, 64'(col_tile_index), 64'(ci));
        step();
    endtask

    // Counts job_done pulses over a fixed window; exactly one is expected.
    task automatic wait_done(input string tag);
        int unsigned pulses = 0;
        for (int unsigned c = 0; c < 6; c++) begin
            step();
            if (job_done) pulses++;
        end
        chk({tag, "_done_pulses"}, 64'(pulses), 64'd1);
        chk({tag, "_ready_after"}, 64'(job_ready), 64'd1);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic run_2x3(input string tag);
        wait_a({tag, "_A0"}, 64'h1000, 13'd8, 11'd3, 11'd0);
        wait_b({tag, "_B00"}, 64'h2000, 13'd8, 11'd0);
        wait_b({tag, "_B01"}, 64'h2020, 13'd8, 11'd1);
        wait_b({tag, "_B02"}, 64'h2040, 13'd8, 11'd2);
    endtask

    initial begin
        reset_n             = 1'b0;
        job_valid           = 1'b0;
        a_instruction_ready = 1'b1;
        b_instruction_ready = 1'b1;
        set_job(64'h0, 64'h0, 13'd0, 11'd0, 11'd0);

        // Reset state
        #3;
        chk("rst_a_valid", 64'(a_instruction_valid), 64'd0);
        chk("rst_b_valid", 64'(b_instruction_valid), 64'd0);
        chk("rst_done", 64'(job_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_a_addr", a_address, 64'd0);
        chk("rst_row_idx", 64'(row_tile_index), 64'd0);
        #9;
        reset_n = 1'b1;
        step();
        chk("rel_job_ready", 64'(job_ready), 64'd1);

        // 2x3 job at full throughput
        set_job(64'h1000, 64'h2000, 13'd8, 11'd2, 11'd3);
        accept_job();
        chk("t2_busy", 64'(busy), 64'd1);
        chk("t2_job_ready", 64'(job_ready), 64'd0);
        run_2x3("t2");
        wait_a("t2_A1", 64'h1020, 13'd8, 11'd3, 11'd1);
        wait_b("t2_B10", 64'h2000, 13'd8, 11'd0);
        wait_b("t2_B11", 64'h2020, 13'd8, 11'd1);
        wait_b("t2_B12", 64'h2040, 13'd8, 11'd2);
        wait_done("t2");

        // Backpressure on the second A instruction
        accept_job();
        run_2x3("t3");
        a_instruction_ready = 1'b0;
        for (int unsigned c = 0; c < 10; c++) begin
            chk("t3_hold_valid", 64'(a_instruction_valid), 64'd1);
            chk("t3_hold_addr", a_address, 64'h1020);
            step();
        end
        chk("t3_hold_b_valid", 64'(b_instruction_valid), 64'd0);
        a_instruction_ready = 1'b1;
        wait_a("t3_A1", 64'h1020, 13'd8, 11'd3, 11'd1);
        wait_b("t3_B10", 64'h2000, 13'd8, 11'd0);
        wait_b("t3_B11", 64'h2020, 13'd8, 11'd1);
        wait_b("t3_B12", 64'h2040, 13'd8, 11'd2);
        wait_done("t3");

        // Empty job: col_tiles = 0
        set_job(64'h1000, 64'h2000, 13'd8, 11'd2, 11'd0);
        accept_job();
        chk("t4_done", 64'(job_done), 64'd1);
        chk("t4_a_valid", 64'(a_instruction_valid), 64'd0);
        chk("t4_b_valid", 64'(b_instruction_valid), 64'd0);
        chk("t4_job_ready", 64'(job_ready), 64'd0);
        step();
        chk("t4_done_clear", 64'(job_done), 64'd0);
        chk("t4_job_ready_back", 64'(job_ready), 64'd1);
        chk("t4_a_valid2", 64'(a_instruction_valid), 64'd0);
        chk("t4_b_valid2", 64'(b_instruction_valid), 64'd0);

        // Address wrap
        set_job(64'hFFFF_FFFF_FFFF_FFE0, 64'h3000, 13'd8, 11'd2, 11'd1);
        accept_job();
        wait_a("t5_A0", 64'hFFFF_FFFF_FFFF_FFE0, 13'd8, 11'd1, 11'd0);
        wait_b("t5_B00", 64'h3000, 13'd8, 11'd0);
        wait_a("t5_A1", 64'h0, 13'd8, 11'd1, 11'd1);
        wait_b("t5_B10", 64'h3000, 13'd8, 11'd0);
        wait_done("t5");

        // job_valid held high while busy; fields changed after accept
        set_job(64'h100, 64'h200, 13'd4, 11'd1, 11'd1);
        job_valid = 1'b1;
        step();
        a_base_address = 64'h500;
        chk("t6_busy", 64'(busy), 64'd1);
        chk("t6_job_ready", 64'(job_ready), 64'd0);
        wait_a("t6_A0", 64'h100, 13'd4, 11'd1, 11'd0);
        wait_b("t6_B00", 64'h200, 13'd4, 11'd0);
        chk("t6_drain_ready", 64'(job_ready), 64'd0);
        step();
        chk("t6_done", 64'(job_done), 64'd1);
        chk("t6_done_ready", 64'(job_ready), 64'd0);
        step();
        chk("t6_idle_ready", 64'(job_ready), 64'd1);
        chk("t6_idle_a_valid", 64'(a_instruction_valid), 64'd0);
        step();
        job_valid = 1'b0;
        chk("t6_second_a_valid", 64'(a_instruction_valid), 64'd1);
        chk("t6_second_a_addr", a_address, 64'h500);
        wait_a("t6_A0b", 64'h500, 13'd4, 11'd1, 11'd0);
        wait_b("t6_B00b", 64'h200, 13'd4, 11'd0);
        wait_done("t6");

        // Reset mid-job
        set_job(64'h1000, 64'h2000, 13'd8, 11'd2, 11'd3);
        accept_job();
        step();
        step();
        chk("t1_pre_b_valid", 64'(b_instruction_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t1_a_valid", 64'(a_instruction_valid), 64'd0);
        chk("t1_b_valid", 64'(b_instruction_valid), 64'd0);
        chk("t1_done", 64'(job_done), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_b_addr", b_address, 64'd0);
        chk("t1_col_idx", 64'(col_tile_index), 64'd0);
        #1;
        reset_n = 1'b1;
        step();
        chk("t1_job_ready", 64'(job_ready), 64'd1);
        chk("t1_a_valid_after", 64'(a_instruction_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
